// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer. It holds the PLL in reset, waits for a synchronized lock with a
// timeout, and qualifies lock stability before it releases the datapath reset. Loss of lock restarts the sequence.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 64,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned LOSS_FILTER   = 4,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       soft_rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       dsp_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [2:0] state,
  output logic [1:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam int unsigned CNT_MAX = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
  localparam int unsigned CW = $clog2(CNT_MAX) + 1;
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT) + 1;
  localparam int unsigned LW = $clog2(LOSS_FILTER) + 1;

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic [1:0]    retry_q, retry_d;
  logic [1:0]    retry_inc;
  logic [7:0]    loss_q, loss_d;
  logic          sync1_q, lk_s_q;
  logic          pll_rst_q, dsp_rst_n_q, ready_q, fail_q;
  logic          timeout;

  assign retry_inc = retry_q + 2'd1;
  assign timeout   = (tmo_q == TW'(LOCK_TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    lcnt_d  = lcnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    if (soft_rst) begin
      state_d = S_RESET_PLL;
      cnt_d   = '0;
      tmo_d   = '0;
      lcnt_d  = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        S_RESET_PLL: begin
          if (cnt_q == CW'(RST_CYCLES - 1)) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
            tmo_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WAIT_LOCK, S_STABILIZE: begin
          // The timeout spans both lock-wait states and wins over any lock-driven move.
          if (timeout) begin
            retry_d = retry_inc;
            cnt_d   = '0;
            state_d = (32'(retry_inc) == MAX_RETRIES) ? S_FAIL : S_RESET_PLL;
          end else begin
            tmo_d = tmo_q + 1'b1;
            if (state_q == S_WAIT_LOCK) begin
              if (lk_s_q) begin
                state_d = S_STABILIZE;
                cnt_d   = '0;
              end
            end else if (!lk_s_q) begin
              state_d = S_WAIT_LOCK;
            end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
              state_d = S_RUN;
              retry_d = '0;
              tmo_d   = '0;
              lcnt_d  = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (lk_s_q) begin
            lcnt_d = '0;
          end else if (lcnt_q == LW'(LOSS_FILTER - 1)) begin
            state_d = S_RESET_PLL;
            cnt_d   = '0;
            lcnt_d  = '0;
            if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
          end else begin
            lcnt_d = lcnt_q + 1'b1;
          end
        end
        S_FAIL: ;
        default: begin
          state_d = S_RESET_PLL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      tmo_q       <= '0;
      lcnt_q      <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      sync1_q     <= 1'b0;
      lk_s_q      <= 1'b0;
      pll_rst_q   <= 1'b1;
      dsp_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      lcnt_q      <= lcnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      sync1_q     <= pll_locked;
      lk_s_q      <= sync1_q;
      // Output flops are loaded from the next state, so they change on the same edge as the state does.
      pll_rst_q   <= (state_d == S_RESET_PLL) || (state_d == S_FAIL);
      dsp_rst_n_q <= (state_d == S_RUN);
      ready_q     <= (state_d == S_RUN);
      fail_q      <= (state_d == S_FAIL);
    end
  end

  assign pll_rst   = pll_rst_q;
  assign dsp_rst_n = dsp_rst_n_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign state     = state_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;

endmodule
